err_steer_sel: RTL and testbench

ERR_STEER_SEL -- requirements
Module: err_steer_sel

---
 rtl/err_steer_sel.sv | 161 ++++++++++++++++
 tb/tb_err_steer_sel.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/err_steer_sel.sv
// Line-follower error selector: tracks the sensor error, coasts on brief line loss, then steers open-loop.
// Optional macro ERR_STEER_SAT_EN clamps every loaded error value to the signed 12-bit range.
module err_steer_sel #(
    parameter int WIDTH    = 16,
    parameter int LOST_CNT = 4,
    parameter int FIND_CNT = 2,
    parameter int TMO_W    = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic [WIDTH-1:0] err_raw,
    input  logic             err_vld,
    input  logic             line_present,
    input  logic [WIDTH-1:0] err_opn_lp,
    output logic [WIDTH-1:0] error,
    output logic             err_vld_o,
    output logic [1:0]       mode,
    output logic             lost
);

    // Strobe protocol: err_vld is a one-clock qualifier with no back-pressure; every strobe
    // accepted outside IDLE yields exactly one err_vld_o pulse one clock later, error valid with it.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        COAST = 2'd2,
        OPEN  = 2'd3
    } state_t;

    localparam int MW = $clog2(LOST_CNT + 1);
    localparam int HW = $clog2(FIND_CNT + 1);
    localparam logic [MW-1:0]    MISS_MAX = MW'(LOST_CNT);
    localparam logic [HW-1:0]    HIT_MAX  = HW'(FIND_CNT);
    localparam logic [TMO_W-1:0] TMO_MAX  = '1;

`ifdef ERR_STEER_SAT_EN
    localparam logic signed [WIDTH-1:0] SAT_MAX = WIDTH'(2047);
    localparam logic signed [WIDTH-1:0] SAT_MIN = WIDTH'(-2048);

    function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v);
        if ($signed(v) > SAT_MAX) return SAT_MAX;
        if ($signed(v) < SAT_MIN) return SAT_MIN;
        return v;
    endfunction
`else
    function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v);
        return v;
    endfunction
`endif

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   error_q, error_d;
    logic               vld_q, vld_d;
    logic [MW-1:0]      miss_q, miss_d, miss_inc;
    logic [HW-1:0]      hit_q, hit_d, hit_inc;
    logic [TMO_W-1:0]   tmo_q, tmo_d, tmo_inc;
    logic               lost_q, lost_d;

    // Saturating increments; counters never wrap.
    assign miss_inc = (miss_q == MISS_MAX) ? miss_q : miss_q + 1'b1;
    assign hit_inc  = (hit_q == HIT_MAX)   ? hit_q  : hit_q + 1'b1;
    assign tmo_inc  = (tmo_q == TMO_MAX)   ? tmo_q  : tmo_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            error_q <= '0;
            vld_q   <= 1'b0;
            miss_q  <= '0;
            hit_q   <= '0;
            tmo_q   <= '0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            error_q <= error_d;
            vld_q   <= vld_d;
            miss_q  <= miss_d;
            hit_q   <= hit_d;
            tmo_q   <= tmo_d;
            lost_q  <= lost_d;
        end
    end

    always_comb begin
        state_d = state_q;
        error_d = error_q;
        vld_d   = 1'b0;
        miss_d  = miss_q;
        hit_d   = hit_q;
        tmo_d   = tmo_q;
        lost_d  = lost_q;

        if (!go) begin
            state_d = IDLE;
            miss_d  = '0;
            hit_d   = '0;
            tmo_d   = '0;
            lost_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: state_d = TRACK;
                TRACK: begin
                    if (err_vld) begin
                        vld_d = 1'b1;
                        if (line_present) begin
                            error_d = clamp(err_raw);
                            miss_d  = '0;
                        end else begin
                            miss_d  = MW'(1);
                            state_d = COAST;
                        end
                    end
                end
                COAST: begin
                    if (err_vld) begin
                        vld_d = 1'b1;
                        if (line_present) begin
                            error_d = clamp(err_raw);
                            miss_d  = '0;
                            state_d = TRACK;
                        end else begin
                            miss_d = miss_inc;
                            if (miss_inc == MISS_MAX) begin
                                state_d = OPEN;
                                tmo_d   = '0;
                                hit_d   = '0;
                                error_d = clamp(err_opn_lp);
                            end
                        end
                    end
                end
                OPEN: begin
                    // Timeout runs on every clock in OPEN, including the clock that leaves it.
                    tmo_d = tmo_inc;
                    if (tmo_inc == TMO_MAX) lost_d = 1'b1;
                    if (err_vld) begin
                        vld_d = 1'b1;
                        if (line_present && (hit_inc == HIT_MAX)) begin
                            state_d = TRACK;
                            error_d = clamp(err_raw);
                            miss_d  = '0;
                            hit_d   = '0;
                        end else begin
                            hit_d   = line_present ? hit_inc : '0;
                            error_d = clamp(err_opn_lp);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign error     = error_q;
    assign err_vld_o = vld_q;
    assign mode      = state_q;
    assign lost      = lost_q;

endmodule

// File: tb/tb_err_steer_sel.sv
// Self-checking bench for err_steer_sel: directed scenarios plus randomized traffic against a behavioural model.
module tb_err_steer_sel;
    localparam int WIDTH   = 16;
    localparam int LOST    = 4;
    localparam int FIND    = 2;
    localparam int TMO_W   = 4;
    localparam int TMO_MAX = (1 << TMO_W) - 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        go = 1'b0;
    logic        err_vld = 1'b0;
    logic        line_present = 1'b0;
    logic [15:0] err_raw = '0;
    logic [15:0] err_opn_lp = '0;
    logic [15:0] error;
    logic        err_vld_o;
    logic [1:0]  mode;
    logic        lost;

    int tests = 0;
    int fails = 0;

    // Behavioural model: mode 0 idle, 1 track, 2 coast, 3 open
    int          m_mode = 0;
    int          m_miss = 0;
    int          m_hit  = 0;
    int          m_tmo  = 0;
    bit          m_lost = 1'b0;
    bit          m_vld  = 1'b0;
    logic [15:0] m_err  = '0;
    logic [15:0] exp_q[$];

    err_steer_sel #(
        .WIDTH(WIDTH), .LOST_CNT(LOST), .FIND_CNT(FIND), .TMO_W(TMO_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .err_raw(err_raw), .err_vld(err_vld),
        .line_present(line_present), .err_opn_lp(err_opn_lp), .error(error),
        .err_vld_o(err_vld_o), .mode(mode), .lost(lost)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] sat(input logic [15:0] v);
`ifdef ERR_STEER_SAT_EN
        int s;
        s = $signed(v);
        if (s > 2047) return 16'h07FF;
        if (s < -2048) return 16'hF800;
`endif
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input bit g, input bit v, input bit lp,
                                input logic [15:0] raw, input logic [15:0] opn);
        m_vld = 1'b0;
        if (!g) begin
            m_mode = 0; m_miss = 0; m_hit = 0; m_tmo = 0; m_lost = 1'b0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (v) begin
                m_vld = 1'b1;
                if (lp) begin m_err = sat(raw); m_miss = 0; end
                else begin m_miss = 1; m_mode = 2; end
            end
        end else if (m_mode == 2) begin
            if (v) begin
                m_vld = 1'b1;
                if (lp) begin
                    m_err = sat(raw); m_miss = 0; m_mode = 1;
                end else begin
                    m_miss = (m_miss + 1 > LOST) ? LOST : m_miss + 1;
                    if (m_miss >= LOST) begin
                        m_mode = 3; m_tmo = 0; m_hit = 0; m_err = sat(opn);
                    end
                end
            end
        end else begin
            m_tmo = (m_tmo + 1 > TMO_MAX) ? TMO_MAX : m_tmo + 1;
            if (m_tmo == TMO_MAX) m_lost = 1'b1;
            if (v) begin
                m_vld = 1'b1;
                m_hit = lp ? ((m_hit + 1 > FIND) ? FIND : m_hit + 1) : 0;
                if (m_hit >= FIND) begin
                    m_mode = 1; m_err = sat(raw); m_miss = 0; m_hit = 0;
                end else begin
                    m_err = sat(opn);
                end
            end
        end
    endtask

    task automatic step(input bit g, input bit v, input bit lp,
                        input logic [15:0] raw, input logic [15:0] opn);
        logic [15:0] e;
        go = g; err_vld = v; line_present = lp; err_raw = raw; err_opn_lp = opn;
        @(posedge clk);
        model_update(g, v, lp, raw, opn);
        if (m_vld) exp_q.push_back(m_err);
        #1;
        chk("vld_o", err_vld_o, m_vld);
        chk("error", error, m_err);
        chk("mode", mode, m_mode);
        chk("lost", lost, m_lost);
        if (err_vld_o === 1'b1) begin
            chk("sb_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_data", error, e);
            end
        end
    endtask

    initial begin
        int bias;
        bit lp_seq[4];

        // Reset values while rst_n is held low
        repeat (2) @(posedge clk);
        #1;
        chk("rst_error", error, 16'h0000);
        chk("rst_vld", err_vld_o, 1'b0);
        chk("rst_mode", mode, 2'd0);
        chk("rst_lost", lost, 1'b0);
        #3 rst_n = 1'b1;

        // First clock with go enters TRACK; basic load
        step(1, 0, 0, 16'h0, 16'h0);
        chk("first_track", mode, 2'd1);
        step(1, 1, 1, 16'h0123, 16'h0);
        chk("d037_vld", err_vld_o, 1'b1);
        chk("d037_err", error, 16'h0123);
        chk("d037_mode", mode, 2'd1);

        // Line loss: coast three strobes, then open-loop on the fourth (back-to-back strobes)
        step(1, 1, 1, 16'h0050, 16'h0);
        for (int i = 1; i <= 4; i++) begin
            step(1, 1, 0, 16'($urandom), 16'hFF00);
            chk("d038_vld", err_vld_o, 1'b1);
            chk("d038_err", error, (i < 4) ? 16'h0050 : 16'hFF00);
            chk("d038_mode", mode, (i < 4) ? 2'd2 : 2'd3);
        end

        // Reacquire from OPEN after FIND consecutive line hits
        lp_seq = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            step(1, 1, lp_seq[i], 16'h0010, 16'hFF00);
            chk("d039_mode", mode, (i < 3) ? 2'd3 : 2'd1);
            if (i == 3) chk("d039_err", error, 16'h0010);
        end

        // Open-loop timeout sets lost without leaving OPEN; go low clears it
        for (int i = 0; i < 4; i++) step(1, 1, 0, 16'h0, 16'h0040);
        chk("d040_open", mode, 2'd3);
        for (int i = 0; i < 14; i++) step(1, 0, 0, 16'h0, 16'h0);
        chk("d040_not_yet", lost, 1'b0);
        step(1, 0, 0, 16'h0, 16'h0);
        chk("d040_lost", lost, 1'b1);
        chk("d040_mode", mode, 2'd3);
        step(1, 0, 0, 16'h0, 16'h0);
        chk("d040_sticky", lost, 1'b1);
        step(0, 0, 0, 16'h0, 16'h0);
        chk("d040_idle", mode, 2'd0);
        chk("d040_clr", lost, 1'b0);

        // Strobe coincident with go falling is dropped
        step(1, 0, 0, 16'h0, 16'h0);
        step(1, 1, 1, 16'h0234, 16'h0);
        step(0, 1, 1, 16'h0999, 16'h0);
        chk("d041_vld", err_vld_o, 1'b0);
        chk("d041_err", error, 16'h0234);
        chk("d041_mode", mode, 2'd0);

        // Saturation option
        step(1, 0, 0, 16'h0, 16'h0);
        step(1, 1, 1, 16'h1000, 16'h0);
`ifdef ERR_STEER_SAT_EN
        chk("d042_pos", error, 16'h07FF);
`else
        chk("d042_pos", error, 16'h1000);
`endif
        step(1, 1, 1, 16'hE000, 16'h0);
`ifdef ERR_STEER_SAT_EN
        chk("d042_neg", error, 16'hF800);
`else
        chk("d042_neg", error, 16'hE000);
`endif

        // Randomized traffic with line-presence bias changing per block
        for (int blk = 0; blk < 8; blk++) begin
            bias = (blk % 2 == 0) ? 25 : 80;
            for (int i = 0; i < 60; i++) begin
                step($urandom_range(0, 39) != 0, $urandom_range(0, 2) != 0,
                     $urandom_range(0, 99) < bias, 16'($urandom), 16'($urandom));
            end
        end

        // Reset mid-operation abandons the pending pulse
        step(1, 1, 1, 16'h0077, 16'h0);
        go = 1'b1; err_vld = 1'b1; line_present = 1'b1; err_raw = 16'h0ABC;
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_vld", err_vld_o, 1'b0);
        chk("mrst_err", error, 16'h0000);
        chk("mrst_mode", mode, 2'd0);
        @(posedge clk);
        #1;
        chk("mrst_hold", err_vld_o, 1'b0);
        m_mode = 0; m_miss = 0; m_hit = 0; m_tmo = 0; m_lost = 1'b0; m_err = '0;
        exp_q.delete();
        go = 1'b0; err_vld = 1'b0;
        #3 rst_n = 1'b1;
        step(1, 0, 0, 16'h0, 16'h0);
        chk("mrst_track", mode, 2'd1);
        step(1, 1, 1, 16'h0321, 16'h0);
        chk("mrst_load", error, 16'h0321);
        step(1, 0, 0, 16'h0, 16'h0);
        chk("sb_drain", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
